// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl
// Reads the Avalon-MM sysid slave (address 0 = system ID, address 1 = build
// timestamp). It then compares both words with the expected parameters and
// reports a verdict.
//
// Ports
//   clock            single clock, rising edge
//   reset            asynchronous active-high reset
//   start            single-cycle request to run a check sequence
//   avm_address      read address (0 = ID, 1 = timestamp), registered
//   avm_read         read strobe, registered
//   avm_waitrequest  slave stall
//   avm_readdata     slave read data
//   busy             a sequence is in progress
//   done             sequence finished, held until next start or reset
//   pass             done with err_code == 0
//   err_code         0 ok, 1 ID mismatch, 2 timestamp mismatch, 3 timeout
//   id_value         last captured ID word
//   ts_value         last captured timestamp word
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1479449597,
  parameter bit          AUTO_START  = 1'b1,
  parameter int          TIMEOUT     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, DONE} state_t;

  // Give up on the edge where the counter would reach TIMEOUT.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic        auto_pending;
  logic [7:0]  wait_cnt;
  logic        in_read;
  logic        timeout_hit;

  assign in_read     = (state == RD_ID) || (state == RD_TS);
  assign timeout_hit = in_read && avm_waitrequest && (wait_cnt == TIMEOUT_LAST);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Auto-start and an explicit start in IDLE both
  // lead to the same single transition. A start while busy is not
  // looked at.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start || auto_pending) next_state = RD_ID;
      RD_ID:   if (!avm_waitrequest) next_state = RD_TS;
               else if (timeout_hit) next_state = DONE;
      RD_TS:   if (!avm_waitrequest) next_state = CHECK;
               else if (timeout_hit) next_state = DONE;
      CHECK:   next_state = DONE;
      DONE:    if (start) next_state = RD_ID;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered bus outputs.
  // The bus strobes are derived from next_state. They therefore change
  // only on state transitions and stay constant while the slave stalls.
  // auto_pending is armed by reset and consumed by the first edge after
  // reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      auto_pending <= AUTO_START;
      wait_cnt     <= 8'd0;
      id_value     <= 32'd0;
      ts_value     <= 32'd0;
      err_code     <= 2'd0;
      avm_read     <= 1'b0;
      avm_address  <= 1'b0;
    end else begin
      auto_pending <= 1'b0;
      avm_read     <= (next_state == RD_ID) || (next_state == RD_TS);
      avm_address  <= (next_state == RD_TS);

      if ((next_state != state) && ((next_state == RD_ID) || (next_state == RD_TS))) begin
        wait_cnt <= 8'd0;
      end else if (in_read && avm_waitrequest) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if ((state == RD_ID) && !avm_waitrequest) id_value <= avm_readdata;
      if ((state == RD_TS) && !avm_waitrequest) ts_value <= avm_readdata;

      if (state == DONE && start) begin
        err_code <= 2'd0;
      end else if (timeout_hit) begin
        err_code <= 2'd3;
      end else if (state == CHECK) begin
        if (id_value != EXPECTED_ID)      err_code <= 2'd1;
        else if (ts_value != EXPECTED_TS) err_code <= 2'd2;
        else                              err_code <= 2'd0;
      end
    end
  end

  // Status outputs decode directly from the state. Reset therefore
  // clears them without waiting for a clock edge.
  always_comb begin
    busy = (state == RD_ID) || (state == RD_TS) || (state == CHECK);
    done = (state == DONE);
    pass = (state == DONE) && (err_code == 2'd0);
  end

endmodule

// File: doc/sysid_check_ctrl.md
SYSID_CHECK_CTRL -- requirements
Module: sysid_check_ctrl

Interface
REQ-001 The block SHALL have parameter EXPECTED_ID, default 0, the 32-bit system ID expected at address 0.
REQ-002 The block SHALL have parameter EXPECTED_TS, default 1479449597, the 32-bit build timestamp expected at address 1.
REQ-003 The block SHALL have parameter AUTO_START, default 1; when 1, a check sequence starts automatically after reset release.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, the maximum number of consecutive waitrequest cycles tolerated per read (range 1..255).
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: single-cycle request to run a check sequence.
REQ-008 The block SHALL have port avm_address, output, 1 bit: Avalon-MM read address to the sysid slave (0 = ID, 1 = timestamp).
REQ-009 The block SHALL have port avm_read, output, 1 bit: Avalon-MM read strobe.
REQ-010 The block SHALL have port avm_waitrequest, input, 1 bit: slave stall; tie low for a zero-wait slave.
REQ-011 The block SHALL have port avm_readdata, input, 32 bits: slave read data, valid in the cycle where avm_read=1 and avm_waitrequest=0.
REQ-012 The block SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: the sequence has finished; held until the next start or reset.
REQ-014 The block SHALL have port pass, output, 1 bit: done=1 and err_code=0.
REQ-015 The block SHALL have port err_code, output, 2 bits: 0 = ok, 1 = ID mismatch, 2 = timestamp mismatch, 3 = timeout.
REQ-016 The block SHALL have ports id_value and ts_value, outputs, 32 bits each: last captured ID and timestamp words.

Function
REQ-017 The FSM SHALL have the states IDLE, RD_ID, RD_TS, CHECK and DONE.
REQ-018 IDLE SHALL go to RD_ID on start=1, or on the first edge after reset release when AUTO_START=1.
REQ-019 In RD_ID, the block SHALL drive avm_read=1 and avm_address=0; it SHALL capture avm_readdata into id_value and go to RD_TS on the edge where avm_waitrequest=0.
REQ-020 In RD_TS, the block SHALL drive avm_read=1 and avm_address=1; it SHALL capture avm_readdata into ts_value and go to CHECK on the edge where avm_waitrequest=0.
REQ-021 avm_address and avm_read SHALL be registered outputs that are stable while avm_waitrequest=1; avm_read=0 in IDLE, CHECK and DONE.
REQ-022 An 8-bit wait counter SHALL clear on entry to each read state and increment on every edge with avm_waitrequest=1.
REQ-023 If the wait counter reaches TIMEOUT, the FSM SHALL go to DONE with err_code=3, deassert avm_read and leave the value registers unchanged for the aborted read.
REQ-024 CHECK SHALL last exactly one cycle and then go to DONE with err_code as follows:
  - 1 if id_value≠EXPECTED_ID; ID mismatch has priority when both mismatch.
  - else 2 if ts_value≠EXPECTED_TS.
  - else 0.
REQ-025 Compares SHALL be full 32-bit unsigned equality.
REQ-026 busy SHALL be 1 in RD_ID, RD_TS and CHECK, and 0 otherwise.
REQ-027 done SHALL be 1 only in DONE; pass SHALL equal done AND (err_code==0).
REQ-028 Latency with avm_waitrequest=0 SHALL be 4 edges from the accepting edge to done=1.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 start in DONE SHALL, on the next edge, clear done, pass and err_code and enter RD_ID; id_value and ts_value SHALL hold until recaptured.
REQ-031 start and auto-start in the same cycle SHALL produce one sequence.

Reset
REQ-032 reset=1 SHALL immediately force the following, without waiting for a clock edge:
  - state to IDLE;
  - avm_read, avm_address, busy, done, pass, err_code, id_value, ts_value and the wait counter to 0.
REQ-033 Reset asserted mid-read SHALL abort the transaction with avm_read low in the same cycle; no partial result SHALL be reported.
REQ-034 After reset release, AUTO_START=1 SHALL start exactly one sequence; AUTO_START=0 SHALL remain in IDLE until start.

Verification
REQ-035 Zero-wait slave returning 0 and 1479449597, AUTO_START=1 -> reads at addr 0 then addr 1, done=1 and pass=1 four edges after reset release, err_code=0.
REQ-036 Slave returning 0x00000005 at addr 0 and a wrong value at addr 1 -> done=1, pass=0, err_code=1, id_value=0x00000005.
REQ-037 Correct ID, timestamp 1479449598 -> err_code=2, ts_value=1479449598, pass=0.
REQ-038 avm_waitrequest held high in RD_TS with TIMEOUT=4 -> avm_read and address=1 stable for 4 cycles, then done=1, err_code=3, avm_read=0.
REQ-039 avm_waitrequest=1 for 3 cycles in RD_ID, then 0 -> avm_address and avm_read stable throughout, id_value captured on the release edge, sequence passes.
REQ-040 reset pulsed during RD_ID, then start pulsed in DONE and pulsed again while busy (AUTO_START=0) -> outputs zero during reset, exactly one sequence per accepted start, done/pass/err_code cleared one edge after the accepted start.
